// File: rtl/stoplight_timer.sv
// stoplight_timer: environment-side companion to the stoplight controller FSM.
//   Turns the FSM lamp/counter controls into a one-cycle count_max pulse
//   and conditions a bouncing pushbutton into a latched pedestrian request.
// Latency: count_max is combinational from the current state; button rises
//   3+DEBOUNCE edges after btn_raw is first sampled high.
// Backpressure: none. The FSM owns count_en/count_clr; a request is held
//   until yellow clears it.
// Ports:
//   clk, nrst        clock, async active-low reset
//   btn_raw          raw pushbutton (async, may bounce)
//   red/yellow/green FSM lamp outputs (select the phase duration)
//   count_en         advance the timer
//   count_clr        clear the timer (wins over count_en)
//   count_max        one-cycle pulse when the phase duration has elapsed
//   button           pedestrian request presented to the FSM
//   count_val        current tick count within the phase
// Optional build macro: STOPLIGHT_MIN_GREEN_EN gates button until green has
//   been held for MIN_GREEN_CYCLES clocks.
module stoplight_timer #(
  parameter int PRESCALE         = 4,
  parameter int RED_TICKS        = 8,
  parameter int YELLOW_TICKS     = 3,
  parameter int DEBOUNCE         = 4,
  parameter int MIN_GREEN_CYCLES = 16,
  localparam int MAX_TICKS = (RED_TICKS > YELLOW_TICKS) ? RED_TICKS : YELLOW_TICKS,
  localparam int CW        = $clog2(MAX_TICKS + 1)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          btn_raw,
  input  logic          red,
  input  logic          yellow,
  input  logic          green,
  input  logic          count_en,
  input  logic          count_clr,
  output logic          count_max,
  output logic          button,
  output logic [CW-1:0] count_val
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] RED_LIM    = CW'(RED_TICKS);
  localparam logic [CW-1:0] YEL_LIM    = CW'(YELLOW_TICKS);

  // ---------------------------------------------------------------------
  // Phase timer: prescaler + tick counter
  // ---------------------------------------------------------------------
  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] limit, limit_m1;
  logic          tick;
  logic          at_last;

  always_comb begin
    // red outranks yellow if the FSM ever drives both
    limit = '0;
    if (red) begin
      limit = RED_LIM;
    end else if (yellow) begin
      limit = YEL_LIM;
    end
    limit_m1 = limit - CW'(1);

    tick      = count_en && !count_clr && (presc_q == PRESC_LAST);
    at_last   = (limit != '0) && (cnt_q == limit_m1);
    count_max = tick && at_last;

    presc_d = presc_q;
    cnt_d   = cnt_q;
    if (count_clr) begin
      presc_d = '0;
      cnt_d   = '0;
    end else if (count_en && (limit != '0)) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
      // Self-wrap on the last tick lets the next phase start from zero
      // without the FSM having to pulse count_clr.
      if (tick) begin
        cnt_d = at_last ? '0 : cnt_q + CW'(1);
      end
    end
  end

  assign count_val = cnt_q;

  // ---------------------------------------------------------------------
  // Button: 2-flop synchronizer, debouncer, edge detect, request latch
  // ---------------------------------------------------------------------
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          lvl_q, lvl_d;
  logic          lvl_prev_q, lvl_prev_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          req_q, req_d;
  logic          lvl_rise;

  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    lvl_prev_d = lvl_q;

    // The level only moves after DEBOUNCE consecutive mismatching samples;
    // any matching sample restarts the count.
    lvl_d  = lvl_q;
    dcnt_d = '0;
    if (sync2_q != lvl_q) begin
      if (dcnt_q == DEB_LAST) begin
        lvl_d  = sync2_q;
        dcnt_d = '0;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end

    lvl_rise = lvl_q && !lvl_prev_q;

    // yellow clears and wins over a simultaneous press, so a press that
    // lands during yellow is dropped rather than carried into the next cycle.
    req_d = req_q;
    if (yellow) begin
      req_d = 1'b0;
    end else if (lvl_rise) begin
      req_d = 1'b1;
    end
  end

`ifdef STOPLIGHT_MIN_GREEN_EN
  // ---------------------------------------------------------------------
  // Minimum-green gate: the request stays latched but is only presented
  // once green has been continuously on for MIN_GREEN_CYCLES clocks.
  // ---------------------------------------------------------------------
  localparam int GW = (MIN_GREEN_CYCLES > 0) ? $clog2(MIN_GREEN_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GREEN_SAT = GW'(MIN_GREEN_CYCLES);

  logic [GW-1:0] gcnt_q, gcnt_d;

  always_comb begin
    gcnt_d = '0;
    if (green) begin
      gcnt_d = (gcnt_q == GREEN_SAT) ? gcnt_q : gcnt_q + GW'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      gcnt_q <= '0;
    end else begin
      gcnt_q <= gcnt_d;
    end
  end

  assign button = req_q && (gcnt_q == GREEN_SAT);
`else
  // green and the minimum-green length only matter when the gate is built
  logic         unused_green;
  localparam int unused_min_green = MIN_GREEN_CYCLES;
  assign unused_green = green;

  assign button = req_q;
`endif

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      presc_q    <= '0;
      cnt_q      <= '0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      lvl_q      <= 1'b0;
      lvl_prev_q <= 1'b0;
      dcnt_q     <= '0;
      req_q      <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_prev_d;
      dcnt_q     <= dcnt_d;
      req_q      <= req_d;
    end
  end

endmodule

// File: tb/tb_stoplight_timer.sv
`timescale 1ns/1ps
module tb_stoplight_timer;

  localparam int PRESCALE         = 4;
  localparam int RED_TICKS        = 8;
  localparam int YELLOW_TICKS     = 3;
  localparam int DEBOUNCE         = 4;
  localparam int MIN_GREEN_CYCLES = 16;
  localparam int MAXT     = (RED_TICKS > YELLOW_TICKS) ? RED_TICKS : YELLOW_TICKS;
  localparam int CW       = $clog2(MAXT + 1);
  localparam int POS_WRAP = (1 << CW) * PRESCALE;
`ifdef STOPLIGHT_MIN_GREEN_EN
  localparam bit GATED = 1'b1;
`else
  localparam bit GATED = 1'b0;
`endif

  logic          clk, nrst;
  logic          btn_raw, red, yellow, green, count_en, count_clr;
  logic          count_max, button;
  logic [CW-1:0] count_val;

  int checks = 0;
  int errors = 0;

  stoplight_timer #(
    .PRESCALE(PRESCALE), .RED_TICKS(RED_TICKS), .YELLOW_TICKS(YELLOW_TICKS),
    .DEBOUNCE(DEBOUNCE), .MIN_GREEN_CYCLES(MIN_GREEN_CYCLES)
  ) dut (
    .clk(clk), .nrst(nrst), .btn_raw(btn_raw), .red(red), .yellow(yellow),
    .green(green), .count_en(count_en), .count_clr(count_clr),
    .count_max(count_max), .button(button), .count_val(count_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Timer kept as one integer: enabled cycles elapsed in the phase.
  int m_pos = 0;
  // Button pipeline as raw samples, mismatch run length, accepted level.
  bit m_s1 = 0, m_s2 = 0, m_lvl = 0, m_prev = 0, m_req = 0;
  int m_run = 0, m_g = 0;

  function automatic int lim_of(bit r, bit y);
    return r ? RED_TICKS : (y ? YELLOW_TICKS : 0);
  endfunction

  function automatic bit m_max();
    int l;
    bit tk;
    l  = lim_of(red, yellow);
    tk = count_en && !count_clr && ((m_pos % PRESCALE) == PRESCALE - 1);
    return tk && (l != 0) && ((m_pos / PRESCALE) == l - 1);
  endfunction

  function automatic bit m_button();
    if (GATED) return m_req && (m_g == MIN_GREEN_CYCLES);
    return m_req;
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_pos = 0; m_s1 = 0; m_s2 = 0; m_lvl = 0; m_prev = 0;
      m_req = 0; m_run = 0; m_g = 0;
    end else begin
      int  l;
      bit  mx, rise;
      l  = lim_of(red, yellow);
      mx = m_max();
      if (count_clr) m_pos = 0;
      else if (count_en && l != 0) m_pos = mx ? 0 : (m_pos + 1) % POS_WRAP;
      rise  = m_lvl && !m_prev;
      m_req = yellow ? 1'b0 : (rise ? 1'b1 : m_req);
      m_prev = m_lvl;
      if (m_s2 != m_lvl) begin
        m_run = m_run + 1;
        if (m_run == DEBOUNCE) begin
          m_lvl = m_s2;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = btn_raw;
      m_g  = green ? ((m_g < MIN_GREEN_CYCLES) ? m_g + 1 : m_g) : 0;
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // every cycle: DUT against model
  always @(negedge clk) begin
    chk("count_val", int'(count_val), m_pos / PRESCALE);
    chk("count_max", int'(count_max), int'(m_max()));
    chk("button",    int'(button),    int'(m_button()));
  end

  task automatic adv(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(int hi, int lo);
    btn_raw = 1'b1; adv(hi);
    btn_raw = 1'b0; adv(lo);
  endtask

  initial begin
    int left;
    int sel;
    nrst = 1'b0; btn_raw = 0; red = 0; yellow = 0; green = 0;
    count_en = 0; count_clr = 0;
    adv(2);
    chk("rst_val", int'(count_val), 0);
    chk("rst_btn", int'(button), 0);

    // red, enable held from reset release: pulses in cycles 31 and 63
    red = 1; count_en = 1; nrst = 1'b1;
    adv(30); @(negedge clk); chk("t1_max30", int'(count_max), 0);
    adv(1);  @(negedge clk); chk("t1_max31", int'(count_max), 1);
    chk("t1_cv31", int'(count_val), 7);
    adv(1);  @(negedge clk); chk("t1_cv32", int'(count_val), 0);
    adv(31); @(negedge clk); chk("t1_max63", int'(count_max), 1);
    adv(1);

    // yellow from cleared state: pulse in cycle 11, then red 32 cycles later
    count_clr = 1; red = 0; yellow = 1; adv(1);
    count_clr = 0;
    adv(11); @(negedge clk); chk("t2_y11", int'(count_max), 1);
    adv(1); red = 1; yellow = 0;
    adv(30); @(negedge clk); chk("t2_r42", int'(count_max), 0);
    adv(1);  @(negedge clk); chk("t2_r43", int'(count_max), 1);
    adv(1);

    // clear mid red phase with enable still high
    count_clr = 1; adv(1); count_clr = 0;
    adv(20); count_clr = 1;
    @(negedge clk); chk("t3_clr_max", int'(count_max), 0);
    adv(1); count_clr = 0;
    @(negedge clk); chk("t3_cv0", int'(count_val), 0);
    adv(31); @(negedge clk); chk("t3_max", int'(count_max), 1);
    adv(1);

    // bouncing button never accepted
    repeat (6) press(3, 3);
    adv(10); @(negedge clk); chk("t4_bounce", int'(button), 0);
    adv(1);

    // clean press during red: request rises after edge 7
    btn_raw = 1;
    adv(6); @(negedge clk); chk("t4_b6", int'(button), 0);
    adv(1); @(negedge clk); chk("t4_b7", int'(button), int'(!GATED));
    adv(3); btn_raw = 0;
    red = 0; green = 1; count_en = 0;
    adv(20); @(negedge clk); chk("t4_green", int'(button), 1);
    adv(1); green = 0; yellow = 1;
    @(negedge clk); chk("t4_y0", int'(button), 1);
    adv(1); @(negedge clk); chk("t4_y1", int'(button), 0);
    adv(1);

    // press whose accepted edge falls inside yellow is discarded
    press(10, 10);
    @(negedge clk); chk("t5_yel", int'(button), 0);
    adv(1); yellow = 0; red = 1; count_en = 1;
    adv(5); @(negedge clk); chk("t5_red", int'(button), 0);
    adv(1);

    // async reset mid-count with a pending request
    press(10, 9);
    @(negedge clk); chk("t6_pre", int'(button), int'(!GATED));
    adv(1); #2; nrst = 1'b0; #1;
    chk("t6_max", int'(count_max), 0);
    chk("t6_btn", int'(button), 0);
    chk("t6_val", int'(count_val), 0);
    @(posedge clk); #1; nrst = 1'b1;

`ifdef STOPLIGHT_MIN_GREEN_EN
    // minimum green: dropout at cycle 10 restarts the 16-cycle hold
    red = 1; press(10, 6);
    red = 0; green = 1; count_en = 0;
    adv(10); green = 0; adv(1); green = 1;
    adv(15); @(negedge clk); chk("t7_g15", int'(button), 0);
    adv(1);  @(negedge clk); chk("t7_g16", int'(button), 1);
    adv(1); green = 0; yellow = 1; adv(2); yellow = 0;
`endif

    // randomized phases, enables, clears and button activity
    left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (left == 0) begin
        sel = $urandom_range(0, 9);
        red    = (sel <= 3) || (sel == 8);
        yellow = (sel == 4) || (sel == 5) || (sel == 8);
        green  = (sel == 6) || (sel == 7);
        left   = $urandom_range(1, 45);
      end
      left--;
      count_en  = ($urandom_range(0, 7) != 0);
      count_clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 5) == 0) btn_raw = ~btn_raw;
      if ($urandom_range(0, 1499) == 0) begin
        #2; nrst = 1'b0; adv(1); nrst = 1'b1;
      end else begin
        adv(1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stoplight_timer.md
Name: stoplight_timer

Overview:
Environment-side companion to the stoplight controller FSM. Consumes the FSM's lamp and counter-control outputs (red/yellow/green, count_en, count_clr) and returns its inputs: a one-cycle count_max pulse when the current phase duration has elapsed, and a conditioned, latched pedestrian request on button. It contains a prescaler, a phase-duration counter, a button synchronizer/debouncer and a request latch.

Parameters:
PRESCALE, 4, clk cycles per timer tick (>=1)
RED_TICKS, 8, ticks in RED phase (>=1)
YELLOW_TICKS, 3, ticks in YELLOW phase (>=1)
DEBOUNCE, 4, consecutive stable cycles required to accept a button level change (>=1)
MIN_GREEN_CYCLES, 16, clk cycles green must be held before a request is presented (used only with optional feature)

Ports:
clk  in  1  clock
nrst  in  1  reset, asynchronous, active-low
btn_raw  in  1  asynchronous pushbutton, active-high, may bounce
red  in  1  FSM red lamp
yellow  in  1  FSM yellow lamp
green  in  1  FSM green lamp
count_en  in  1  FSM: advance timer
count_clr  in  1  FSM: clear timer
count_max  out  1  one-cycle pulse: phase duration elapsed
button  out  1  latched pedestrian request to FSM
count_val  out  CW  current tick count, CW = $clog2(max(RED_TICKS,YELLOW_TICKS)+1)

Behaviour:
- Reset (nrst=0, async): prescaler=0, count_val=0, sync flops=0, debounced level=0, debounce counter=0, request latch=0, green counter=0; count_max=0, button=0.
- Limit select (comb): red -> RED_TICKS; else yellow -> YELLOW_TICKS; else 0. red has priority if red and yellow are both high.
- tick (comb) = count_en && !count_clr && prescaler==PRESCALE-1.
- Per clock, priority order:
  1. count_clr=1: prescaler<=0, count_val<=0 (wins over count_en).
  2. count_en=1, limit!=0: prescaler increments, wrapping PRESCALE-1 -> 0. On tick: if count_val==limit-1, count_val<=0; else count_val increments.
  3. Otherwise: prescaler and count_val hold.
- count_max (comb) = tick && limit!=0 && count_val==limit-1. Exactly one clk wide. It is never asserted when limit=0 or count_clr=1.
- Timing: from the state prescaler=0, count_val=0, with count_en held and the phase unchanged, count_max is high during cycle index limit*PRESCALE-1 (first enabled cycle = index 0). Self-wrap on count_max means a YELLOW->RED hand-off with count_en continuously high starts RED from 0 without count_clr.
- Button path: btn_raw -> 2-flop synchronizer -> sync. The debounce counter increments while sync != debounced level and resets to 0 on any match. When a mismatch occurs with counter==DEBOUNCE-1, the debounced level <= sync and the counter <= 0.
- Request latch: set on a rising edge of the debounced level; cleared whenever yellow=1. Clear wins over simultaneous set. A press during red is held until the next yellow. A press during yellow is discarded.
- Latency: the first clk edge sampling btn_raw=1 is edge 1. The debounced level rises at edge 2+DEBOUNCE. The request latch and button rise at edge 3+DEBOUNCE.
- Without optional feature: button = request latch.

Optional Feature:
STOPLIGHT_MIN_GREEN_EN
- Defined: adds a green counter that saturates at MIN_GREEN_CYCLES, increments each cycle green=1, and is cleared to 0 in any cycle green=0. button = latch && (green counter == MIN_GREEN_CYCLES). The latch itself is unaffected and stays pending until presented.
- Undefined: green counter absent; button = latch; MIN_GREEN_CYCLES ignored.

Test Plan:
- Defaults, release reset, red=1, count_en=1 held -> count_max high only in cycle 31, count_val wraps 7->0 that edge; next pulse at cycle 63.
- yellow=1, count_en=1 from cleared state -> count_max in cycle 11. Switch to red with count_en still high -> next count_max 32 cycles later.
- red phase, count_clr=1 with count_en=1 at cycle 20 -> count_val=0, prescaler=0; count_max occurs 32 cycles after count_clr deasserts.
- btn_raw pulses 3 cycles high, 3 low, repeated -> button stays 0. Clean 10-cycle press during red -> button=1 at edge 7, held through red/green; clears the cycle after yellow=1.
- Press whose debounced edge lands while yellow=1 -> button stays 0. Reset asserted mid-count with button=1 -> count_max=0, button=0, count_val=0 immediately.
- STOPLIGHT_MIN_GREEN_EN defined, request latched, green rises -> button=0 for 16 cycles, then 1. green dropping at cycle 10 restarts the count.
